// File: rtl/bcd_comparator_seq_if.sv
// Request/result bundle for the sequential packed-BCD magnitude comparator.
// The master issues start with operands; the slave returns status and result flags.
interface bcd_comparator_seq_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic                  a_gt_b;
    logic                  a_lt_b;
    logic                  a_eq_b;
    logic                  bcd_err;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, bcd_err
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, bcd_err
    );
endinterface

// File: rtl/bcd_comparator_seq.sv
// Sequential packed-BCD comparator: captures two operands, validates every digit,
// then walks digit pairs MSD first, exiting on the first difference.
module bcd_comparator_seq #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_comparator_seq_if.slave  bus
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             err_q, err_d;

    logic             in_bad;
    logic [3:0]       dig_a;
    logic [3:0]       dig_b;

    // Validity is judged on the values being captured so the error path can
    // skip COMPARE on the capture edge itself.
    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    always_comb begin
        dig_a = a_q[4*idx_q +: 4];
        dig_b = b_q[4*idx_q +: 4];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    idx_d = IDX_MAX;
                    gt_d  = 1'b0;
                    lt_d  = 1'b0;
                    eq_d  = 1'b0;
                    err_d = in_bad;
                    state_d = in_bad ? DONE : COMPARE;
                end
            end
            COMPARE: begin
                if (dig_a > dig_b) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (dig_a < dig_b) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.a_gt_b  = gt_q;
    assign bus.a_lt_b  = lt_q;
    assign bus.a_eq_b  = eq_q;
    assign bus.bcd_err = err_q;

endmodule

// File: tb/tb_bcd_comparator_seq.sv
// Scoreboard bench for bcd_comparator_seq: a decimal-value reference model predicts
// result flags and done latency for each issued comparison.
module tb_bcd_comparator_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_comparator_seq_if #(.DIGITS(DIGITS)) bus_if ();

    bcd_comparator_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // res = {gt, lt, eq, err}; lat = edges after capture until done is seen
    typedef struct {
        logic [3:0] res;
        int         lat;
    } result_t;

    result_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        result_t      r;
        logic [W-1:0] x;
        longint       av = 0;
        longint       bv = 0;
        bit           bad = 0;
        int           top = -1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
            av = av * 10 + longint'(a[4*i +: 4]);
            bv = bv * 10 + longint'(b[4*i +: 4]);
        end
        if (bad) begin
            r.res = 4'b0001;
            r.lat = 0;
            return r;
        end
        x = a ^ b;
        for (int i = 0; i < W; i++) if (x[i]) top = i;
        r.lat = (top < 0) ? DIGITS : DIGITS - top / 4;
        r.res = (av > bv) ? 4'b1000 : (av < bv) ? 4'b0100 : 4'b0010;
        return r;
    endfunction

    function automatic logic [3:0] flags();
        return {bus_if.a_gt_b, bus_if.a_lt_b, bus_if.a_eq_b, bus_if.bcd_err};
    endfunction

    // Waits for IDLE, presents a start, pushes the prediction, returns #1 after capture.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        while (bus_if.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL drive_idle_timeout busy=%b required 0", bus_if.busy);
        end
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        if (!hold) bus_if.start = 1'b0;
    endtask

    task automatic collect(input int start_cyc, output result_t obs);
        int cyc = start_cyc;
        while (!bus_if.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        obs.res = flags();
        obs.lat = bus_if.done ? cyc : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a = '0;
        bus_if.b = '0;
        #3;
        checks++;
        if ({bus_if.busy, bus_if.done, flags()} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 000000", {bus_if.busy, bus_if.done, flags()});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b required 0", bus_if.busy);
        end
    endtask

    task automatic test_equal();
        result_t obs, e;
        drive(16'h1234, 16'h1234, 1'b0);
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL equal_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL equal_lat got %0d required %0d", obs.lat, e.lat);
        end
    endtask

    task automatic test_gt_early();
        result_t obs, e;
        drive(16'h5000, 16'h4999, 1'b0);
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL gt_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL gt_lat got %0d required %0d", obs.lat, e.lat);
        end
    endtask

    task automatic test_lt_hold();
        result_t obs, e;
        drive(16'h1233, 16'h1234, 1'b0);
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL lt_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL lt_lat got %0d required %0d", obs.lat, e.lat);
        end
        bus_if.a = 16'h9999;
        bus_if.b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done, flags()} !== {2'b00, e.res}) begin
            errors++;
            $display("FAIL lt_hold got %b required %b", {bus_if.busy, bus_if.done, flags()}, {2'b00, e.res});
        end
    endtask

    task automatic test_bcd_err();
        result_t obs, e;
        drive(16'h0009, 16'h12A4, 1'b0);
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b11) begin
            errors++;
            $display("FAIL err_direct_done busy,done got %b required 11", {bus_if.busy, bus_if.done});
        end
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL err_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL err_lat got %0d required %0d", obs.lat, e.lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done, flags()} !== {2'b00, e.res}) begin
            errors++;
            $display("FAIL err_one_cycle got %b required %b", {bus_if.busy, bus_if.done, flags()}, {2'b00, e.res});
        end
    endtask

    task automatic test_start_ignored();
        result_t obs, e;
        drive(16'h0100, 16'h0200, 1'b0);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 16'h9999;
        bus_if.b     = 16'h0000;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        collect(1, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL ignore_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL ignore_lat got %0d required %0d", obs.lat, e.lat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart busy got %b required 0", bus_if.busy);
        end
    endtask

    task automatic test_reset_abort();
        result_t obs, e, dummy;
        drive(16'h1234, 16'h1235, 1'b0);
        dummy = sb.pop_back();
        @(posedge clk);
        #2;
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b10) begin
            errors++;
            $display("FAIL abort_in_compare busy,done got %b required 10", {bus_if.busy, bus_if.done});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done, flags()} !== 6'b0) begin
            errors++;
            $display("FAIL abort_outputs got %b required 000000", {bus_if.busy, bus_if.done, flags()});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle %0d got %b required 0", i, bus_if.done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0);
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res) begin
            errors++;
            $display("FAIL after_abort_res got %b required %b", obs.res, e.res);
        end
        checks++;
        if (obs.lat !== e.lat) begin
            errors++;
            $display("FAIL after_abort_lat got %0d required %0d", obs.lat, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        result_t obs, e;
        drive(16'h0042, 16'h0042, 1'b1);
        bus_if.a = 16'h7000;
        bus_if.b = 16'h6000;
        sb.push_back(model(16'h7000, 16'h6000));
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res || obs.lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_first got res %b lat %0d required res %b lat %0d", obs.res, obs.lat, e.res, e.lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy got %b required 0", bus_if.busy);
        end
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        checks++;
        if ({bus_if.busy, flags()} !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_second_capture got %b required 10000", {bus_if.busy, flags()});
        end
        collect(0, obs);
        e = sb.pop_front();
        checks++;
        if (obs.res !== e.res || obs.lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_second got res %b lat %0d required res %b lat %0d", obs.res, obs.lat, e.res, e.lat);
        end
    endtask

    task automatic test_random();
        result_t obs, e;
        logic [W-1:0] a, b;
        for (int n = 0; n < 16; n++) begin
            a = '0;
            b = '0;
            for (int d = 0; d < DIGITS; d++) begin
                a[4*d +: 4] = 4'($urandom_range(0, 9));
                b[4*d +: 4] = ($urandom_range(0, 1) == 0) ? a[4*d +: 4] : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) a[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
                else                           b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            end
            drive(a, b, 1'b0);
            collect(0, obs);
            e = sb.pop_front();
            checks++;
            if (obs.res !== e.res || obs.lat !== e.lat) begin
                errors++;
                $display("FAIL random a=%h b=%h got res %b lat %0d required res %b lat %0d",
                         a, b, obs.res, obs.lat, e.res, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_gt_early();
        test_lt_hold();
        test_bcd_err();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
